// File: rtl/id_scan_ctrl_if.sv
// Character-in / identifier-record-out bundle for id_scan_ctrl.
// Latency: none, wires only.
// Backpressure: in_ready stalls the source and tok_ready stalls the record.
interface id_scan_ctrl_if #(
  parameter int POS_W = 8,
  parameter int LEN_W = 6
);
  logic             in_valid;
  logic [7:0]       in_char;
  logic             in_last;
  logic             in_ready;
  logic             tok_valid;
  logic             tok_ready;
  logic [POS_W-1:0] tok_start;
  logic [LEN_W-1:0] tok_len;
  logic             tok_digit;
  logic             tok_ovf;

  // Character source and record sink side (testbench / upstream)
  modport master (
    output in_valid, in_char, in_last, tok_ready,
    input  in_ready, tok_valid, tok_start, tok_len, tok_digit, tok_ovf
  );

  // Scanner side
  modport slave (
    input  in_valid, in_char, in_last, tok_ready,
    output in_ready, tok_valid, tok_start, tok_len, tok_digit, tok_ovf
  );
endinterface

// File: rtl/id_scan_ctrl.sv
// Small synchronous FIFO used to buffer {char,last} ahead of the scanner.
// Latency: an entry written at edge N is readable after edge N.
// Backpressure: full blocks pushes; the caller only pops when not empty.
module id_scan_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         full,
  input  logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign pop_dat = mem_q[rd_ptr_q];

  // Pointer and occupancy update; push+pop together leaves the count alone
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_vld) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_vld)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_vld, pop_vld})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the entry is not counted
  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// Scans an ASCII stream and emits one {start,len,digit,ovf} record per identifier.
// Latency: char pushed at edge N is consumed at edge N+1; its record is valid after N+1.
// Backpressure: a held record (tok_valid && !tok_ready) freezes pops; FIFO fills, in_ready drops.
module id_scan_ctrl #(
  parameter int DEPTH = 4,
  parameter int POS_W = 8,
  parameter int LEN_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  id_scan_ctrl_if.slave bus,
  output logic          busy
);
  typedef enum logic {IDLE = 1'b0, IN_ID = 1'b1} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] start_q, start_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             digit_q, digit_d;
  logic             ovf_q, ovf_d;

  logic             tok_valid_q, tok_valid_d;
  logic [POS_W-1:0] tok_start_q, tok_start_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic             tok_digit_q, tok_digit_d;
  logic             tok_ovf_q, tok_ovf_d;

  logic       fifo_full, fifo_empty, pop;
  logic [8:0] head;
  logic [7:0] ch;
  logic       ch_last, is_l, is_d, close;

  id_scan_fifo #(.W(9), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (bus.in_valid && !fifo_full),
    .push_dat ({bus.in_char, bus.in_last}),
    .full     (fifo_full),
    .pop_vld  (pop),
    .pop_dat  (head),
    .empty    (fifo_empty)
  );

  assign ch      = head[8:1];
  assign ch_last = head[0];
  assign is_l    = ((ch >= 8'd65) && (ch <= 8'd90)) || ((ch >= 8'd97) && (ch <= 8'd122));
  assign is_d    = (ch >= 8'd48) && (ch <= 8'd57);

  // A pending record that the sink is not taking blocks the whole scanner
  assign pop = !fifo_empty && (!tok_valid_q || bus.tok_ready);

  assign bus.in_ready  = !fifo_full;
  assign bus.tok_valid = tok_valid_q;
  assign bus.tok_start = tok_start_q;
  assign bus.tok_len   = tok_len_q;
  assign bus.tok_digit = tok_digit_q;
  assign bus.tok_ovf   = tok_ovf_q;
  assign busy = !fifo_empty || (state_q == IN_ID) || tok_valid_q;

  // Identifier FSM: classify the popped char, then apply end-of-string handling.
  // The *_d values after both steps are exactly the record to emit on a close,
  // since a closing 'other' char leaves the running identifier untouched.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    start_d = start_q;
    len_d   = len_q;
    digit_d = digit_q;
    ovf_d   = ovf_q;
    close   = 1'b0;
    if (pop) begin
      case (state_q)
        IDLE: begin
          if (is_l) begin
            state_d = IN_ID;
            start_d = pos_q;
            len_d   = LEN_W'(1);
            digit_d = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        IN_ID: begin
          if (is_l || is_d) begin
            if (len_q == LEN_MAX) ovf_d = 1'b1;
            else                  len_d = len_q + LEN_W'(1);
            if (is_d) digit_d = 1'b1;
          end else begin
            close   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (ch_last) begin
        if (state_d == IN_ID) close = 1'b1;
        state_d = IDLE;
        pos_d   = '0;
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end
  end

  // Record register: load on close, otherwise drop valid once accepted
  always_comb begin
    tok_valid_d = tok_valid_q;
    tok_start_d = tok_start_q;
    tok_len_d   = tok_len_q;
    tok_digit_d = tok_digit_q;
    tok_ovf_d   = tok_ovf_q;
    if (close) begin
      tok_valid_d = 1'b1;
      tok_start_d = start_d;
      tok_len_d   = len_d;
      tok_digit_d = digit_d;
      tok_ovf_d   = ovf_d;
    end else if (bus.tok_ready) begin
      tok_valid_d = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Position counter and running identifier fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      start_q <= '0;
      len_q   <= '0;
      digit_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      start_q <= start_d;
      len_q   <= len_d;
      digit_q <= digit_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output record register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_valid_q <= 1'b0;
      tok_start_q <= '0;
      tok_len_q   <= '0;
      tok_digit_q <= 1'b0;
      tok_ovf_q   <= 1'b0;
    end else begin
      tok_valid_q <= tok_valid_d;
      tok_start_q <= tok_start_d;
      tok_len_q   <= tok_len_d;
      tok_digit_q <= tok_digit_d;
      tok_ovf_q   <= tok_ovf_d;
    end
  end
endmodule

// File: tb/tb_id_scan_ctrl.sv
// Directed bench for id_scan_ctrl (DEPTH=4, POS_W=4, LEN_W=3).
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: tok_ready held low in one scenario to fill the FIFO.
module tb_id_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_vec = 0;
  int   n_bad = 0;
  int   push_cnt = 0;
  logic [8:0] rec_q [$];

  id_scan_ctrl_if #(.POS_W(4), .LEN_W(3)) bus ();

  id_scan_ctrl #(.DEPTH(4), .POS_W(4), .LEN_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Capture accepted records and pushes one half-cycle ahead of the edge that takes them
  always @(negedge clk) begin
    if (rst_n && bus.tok_valid && bus.tok_ready)
      rec_q.push_back({bus.tok_start, bus.tok_len, bus.tok_digit, bus.tok_ovf});
    if (rst_n && bus.in_valid && bus.in_ready)
      push_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_rec(input string tag, input int s, input int l, input int d, input int o);
    logic [15:0] e;
    e = {7'd0, 4'(s), 3'(l), 1'(d), 1'(o)};
    if (rec_q.size() == 0) chk(tag, 16'hFFFF, e);
    else                   chk(tag, {7'd0, rec_q.pop_front()}, e);
  endtask

  // Present one char and hold it until accepted; returns 1ns after the accepting edge
  task automatic send(input byte c, input bit last);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    bus.in_last  = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      n++;
    end
    if (!ok) chk("send_timeout", 16'd0, 16'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last && (i == s.len() - 1));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 16'(busy), 16'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] s0;
    logic [2:0] l0;
    int         base;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_char   = 8'd0;
    bus.in_last   = 1'b0;
    bus.tok_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_tok", {7'd0, bus.tok_valid, bus.tok_start, bus.tok_len, bus.tok_ovf}, 16'd0);
    chk("rst_digit", 16'(bus.tok_digit), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-stream drops "ab"
    send_str("ab", 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 16'(busy), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_str("c", 1'b1);
    drain("midrst");
    chk("midrst_cnt", 16'(rec_q.size()), 16'd1);
    exp_rec("midrst_rec", 0, 1, 0, 0);

    // Basic string
    send_str("ab1 c", 1'b1);
    drain("basic");
    chk("basic_cnt", 16'(rec_q.size()), 16'd2);
    exp_rec("basic_rec0", 0, 3, 1, 0);
    exp_rec("basic_rec1", 4, 1, 0, 0);

    // First-record latency on an idle scanner
    send_str("q", 1'b1);
    @(negedge clk);
    chk("lat_early", 16'(bus.tok_valid), 16'd0);
    @(negedge clk);
    chk("lat_valid", 16'(bus.tok_valid), 16'd1);
    chk("lat_start", 16'(bus.tok_start), 16'd0);
    drain("lat");
    rec_q.delete();

    // Digit-led, other-only, digit inside identifier at end of string
    send_str("9x;", 1'b1);
    drain("dlead");
    chk("dlead_cnt", 16'(rec_q.size()), 16'd1);
    exp_rec("dlead_rec", 1, 1, 0, 0);
    send_str("12;", 1'b1);
    drain("nolet");
    chk("nolet_cnt", 16'(rec_q.size()), 16'd0);
    send_str("a9", 1'b1);
    drain("alast");
    exp_rec("alast_rec", 0, 2, 1, 0);

    // Back-pressure: sink stalled, FIFO fills, then everything drains in order
    bus.tok_ready = 1'b0;
    base = push_cnt;
    fork
      send_str("a b c d e f", 1'b1);
      begin
        repeat (20) @(negedge clk);
        chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
        chk("bp_pushes", 16'(push_cnt - base), 16'd6);
        chk("bp_valid", 16'(bus.tok_valid), 16'd1);
        chk("bp_start", 16'(bus.tok_start), 16'd0);
        s0 = bus.tok_start;
        l0 = bus.tok_len;
        repeat (5) @(negedge clk);
        chk("bp_stable", {9'd0, bus.tok_start, bus.tok_len}, {9'd0, s0, l0});
        chk("bp_none_taken", 16'(rec_q.size()), 16'd0);
        @(posedge clk);
        #1;
        bus.tok_ready = 1'b1;
      end
    join
    drain("bp");
    chk("bp_cnt", 16'(rec_q.size()), 16'd6);
    for (int i = 0; i < 6; i++)
      exp_rec($sformatf("bp_rec%0d", i), 2 * i, 1, 0, 0);

    // Length saturation at LEN_W=3
    send_str("abcdefghi ", 1'b1);
    drain("sat");
    chk("sat_cnt", 16'(rec_q.size()), 16'd1);
    exp_rec("sat_rec", 0, 7, 0, 1);

    // Position wrap at POS_W=4
    for (int i = 0; i < 15; i++) send(8'd46, 1'b0);
    send_str("ab", 1'b1);
    drain("wrap");
    chk("wrap_cnt", 16'(rec_q.size()), 16'd1);
    exp_rec("wrap_rec", 15, 2, 0, 0);
    send_str("z", 1'b1);
    drain("wrap2");
    exp_rec("wrap_next", 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
